// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tomasulo_pkg
// Purpose  : Shared sizing defaults, execution-unit codes and opcode ranges
//            for the instruction queue and dispatch stage.
// Revision : 1.0 - initial release
// ============================================================================
package tomasulo_pkg;

  // Default structure sizes (both powers of two)
  localparam int IQ_DEPTH_DEFAULT  = 4;
  localparam int ROB_DEPTH_DEFAULT = 32;

  // Target execution unit, as presented on ds_unit
  typedef enum logic [1:0] {
    UNIT_ADD     = 2'd0,
    UNIT_MUL     = 2'd1,
    UNIT_MEM     = 2'd2,
    UNIT_ILLEGAL = 2'd3
  } unit_e;

  // Opcode ranges on instr[31:28]; add starts at 0 so only its top is kept
  localparam logic [3:0] OPC_ADD_HI = 4'h3;
  localparam logic [3:0] OPC_MUL_LO = 4'h4;
  localparam logic [3:0] OPC_MUL_HI = 4'h5;
  localparam logic [3:0] OPC_MEM_LO = 4'h6;
  localparam logic [3:0] OPC_MEM_HI = 4'h7;

  // Map the major opcode nibble to its execution unit
  function automatic unit_e decode_unit(input logic [3:0] opc);
    unit_e u;
    if (opc <= OPC_ADD_HI) begin
      u = UNIT_ADD;
    end else if (opc >= OPC_MUL_LO && opc <= OPC_MUL_HI) begin
      u = UNIT_MUL;
    end else if (opc >= OPC_MEM_LO && opc <= OPC_MEM_HI) begin
      u = UNIT_MEM;
    end else begin
      u = UNIT_ILLEGAL;
    end
    return u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : iq_fifo
// Purpose  : Instruction-queue storage with head/tail pointers and occupancy.
//            Flush empties the queue; push and pop may happen together.
// Revision : 1.0 - initial release
// ============================================================================
module iq_fifo
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[head_q];

  // Guard against pushing into a full queue or popping an empty one
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers and count; flush wins over push/pop
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop_ok) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Register the queue state; reset clears entries so head_data is defined
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iq_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : iq_dispatch
// Purpose  : In-order dispatch from the instruction queue to the add, mul and
//            mem reservation stations with ROB tag allocation. Undecodable
//            head words are dropped with a one-cycle illegal pulse.
// Revision : 1.0 - initial release
// ============================================================================
module iq_dispatch
  import tomasulo_pkg::*;
#(
  parameter int IQ_DEPTH  = IQ_DEPTH_DEFAULT,
  parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
  localparam int TAG_W = $clog2(ROB_DEPTH),
  localparam int CNT_W = $clog2(IQ_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fe_valid,
  input  logic [31:0]      fe_instr,
  output logic             iq_ready,
  input  logic             flush,
  input  logic             rs_add_ready,
  input  logic             rs_mul_ready,
  input  logic             rs_mem_ready,
  input  logic             rob_full,
  output logic             ds_valid,
  output logic [1:0]       ds_unit,
  output logic [31:0]      ds_instr,
  output logic [TAG_W-1:0] ds_rob_tag,
  output logic             illegal,
  output logic [CNT_W-1:0] iq_count
);

  logic [31:0]      head_instr;
  logic             iq_empty;
  logic             iq_full;
  logic             push;
  logic             pop;
  unit_e            head_unit;
  logic             head_legal;
  logic             unit_ready;
  logic             pop_legal;
  logic             pop_illegal;

  logic             ds_valid_q, ds_valid_d;
  logic [1:0]       ds_unit_q, ds_unit_d;
  logic [31:0]      ds_instr_q, ds_instr_d;
  logic [TAG_W-1:0] ds_rob_tag_q, ds_rob_tag_d;
  logic             illegal_q, illegal_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Readiness comes only from the registered count, so a full queue refuses
  // a push even when the head leaves in the same cycle
  assign iq_ready = !iq_full;
  assign push     = fe_valid && iq_ready && !flush;
  assign pop      = pop_legal || pop_illegal;

  iq_fifo #(
    .DEPTH (IQ_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (fe_instr),
    .pop       (pop),
    .head_data (head_instr),
    .count     (iq_count),
    .empty     (iq_empty),
    .full      (iq_full)
  );

  assign head_unit  = decode_unit(head_instr[31:28]);
  assign head_legal = (head_unit != UNIT_ILLEGAL);

  // Select the reservation-station ready that matches the head's unit
  always_comb begin
    unit_ready = 1'b0;
    case (head_unit)
      UNIT_ADD: unit_ready = rs_add_ready;
      UNIT_MUL: unit_ready = rs_mul_ready;
      UNIT_MEM: unit_ready = rs_mem_ready;
      default:  unit_ready = 1'b0;
    endcase
  end

  // Legal heads need a ready station and a free ROB slot; illegal heads
  // are dropped unconditionally. Flush suppresses both.
  assign pop_legal   = !iq_empty && head_legal && unit_ready && !rob_full && !flush;
  assign pop_illegal = !iq_empty && !head_legal && !flush;

  // Dispatch outputs load only on a legal pop and otherwise hold
  always_comb begin
    ds_valid_d   = pop_legal;
    illegal_d    = pop_illegal;
    ds_unit_d    = ds_unit_q;
    ds_instr_d   = ds_instr_q;
    ds_rob_tag_d = ds_rob_tag_q;
    tag_d        = tag_q;
    if (pop_legal) begin
      ds_unit_d    = head_unit;
      ds_instr_d   = head_instr;
      ds_rob_tag_d = tag_q;
      tag_d        = (tag_q == TAG_W'(ROB_DEPTH - 1)) ? '0 : tag_q + TAG_W'(1);
    end
  end

  // Register dispatch outputs and the tag counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_valid_q   <= 1'b0;
      illegal_q    <= 1'b0;
      ds_unit_q    <= '0;
      ds_instr_q   <= '0;
      ds_rob_tag_q <= '0;
      tag_q        <= '0;
    end else begin
      ds_valid_q   <= ds_valid_d;
      illegal_q    <= illegal_d;
      ds_unit_q    <= ds_unit_d;
      ds_instr_q   <= ds_instr_d;
      ds_rob_tag_q <= ds_rob_tag_d;
      tag_q        <= tag_d;
    end
  end

  assign ds_valid   = ds_valid_q;
  assign illegal    = illegal_q;
  assign ds_unit    = ds_unit_q;
  assign ds_instr   = ds_instr_q;
  assign ds_rob_tag = ds_rob_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_iq_dispatch
// Purpose  : Self-checking bench for iq_dispatch: directed scenarios followed
//            by random traffic, compared against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iq_dispatch;

  localparam int IQ_DEPTH  = 4;
  localparam int ROB_DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe_valid;
  logic [31:0] fe_instr;
  logic        iq_ready;
  logic        flush;
  logic        rs_add_ready;
  logic        rs_mul_ready;
  logic        rs_mem_ready;
  logic        rob_full;
  logic        ds_valid;
  logic [1:0]  ds_unit;
  logic [31:0] ds_instr;
  logic [4:0]  ds_rob_tag;
  logic        illegal;
  logic [2:0]  iq_count;

  always #5 clk = ~clk;

  iq_dispatch #(
    .IQ_DEPTH  (IQ_DEPTH),
    .ROB_DEPTH (ROB_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fe_valid     (fe_valid),
    .fe_instr     (fe_instr),
    .iq_ready     (iq_ready),
    .flush        (flush),
    .rs_add_ready (rs_add_ready),
    .rs_mul_ready (rs_mul_ready),
    .rs_mem_ready (rs_mem_ready),
    .rob_full     (rob_full),
    .ds_valid     (ds_valid),
    .ds_unit      (ds_unit),
    .ds_instr     (ds_instr),
    .ds_rob_tag   (ds_rob_tag),
    .illegal      (illegal),
    .iq_count     (iq_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of words plus the expected output registers
  logic [31:0] mq[$];
  int          m_tag;
  bit          m_valid;
  bit          m_ill;
  int          m_unit;
  logic [31:0] m_instr;
  int          m_rtag;

  function automatic int unit_of(input logic [31:0] w);
    int top;
    top = int'(w[31:28]);
    if (top < 4) return 0;
    if (top < 6) return 1;
    if (top < 8) return 2;
    return 3;
  endfunction

  task automatic model_step();
    bit was_full;
    bit rdy;
    int u;
    if (rst) begin
      mq.delete();
      m_tag = 0; m_valid = 0; m_ill = 0; m_unit = 0; m_instr = '0; m_rtag = 0;
    end else if (flush) begin
      mq.delete();
      m_valid = 0; m_ill = 0;
    end else begin
      was_full = (mq.size() == IQ_DEPTH);
      m_valid  = 0;
      m_ill    = 0;
      if (mq.size() > 0) begin
        u   = unit_of(mq[0]);
        rdy = (u == 0) ? rs_add_ready : (u == 1) ? rs_mul_ready : rs_mem_ready;
        if (u == 3) begin
          void'(mq.pop_front());
          m_ill = 1;
        end else if (rdy && !rob_full) begin
          m_valid = 1;
          m_unit  = u;
          m_instr = mq.pop_front();
          m_rtag  = m_tag;
          m_tag   = (m_tag + 1) % ROB_DEPTH;
        end
      end
      if (fe_valid && !was_full) mq.push_back(fe_instr);
    end
  endtask

  task automatic compare_all();
    check_eq("iq_count",   32'(iq_count),   32'(mq.size()));
    check_eq("iq_ready",   32'(iq_ready),   32'(mq.size() < IQ_DEPTH));
    check_eq("ds_valid",   32'(ds_valid),   32'(m_valid));
    check_eq("illegal",    32'(illegal),    32'(m_ill));
    check_eq("ds_unit",    32'(ds_unit),    32'(m_unit));
    check_eq("ds_instr",   ds_instr,        m_instr);
    check_eq("ds_rob_tag", 32'(ds_rob_tag), 32'(m_rtag));
  endtask

  // One clock: model sees the same pre-edge inputs as the DUT, compare after
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_ready(input bit a, input bit m, input bit e);
    rs_add_ready = a; rs_mul_ready = m; rs_mem_ready = e;
  endtask

  task automatic do_reset();
    rst = 1'b1; fe_valid = 1'b0; flush = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  int seen;

  initial begin
    rst = 1'b1; fe_valid = 1'b0; fe_instr = '0; flush = 1'b0;
    rob_full = 1'b0; set_ready(0, 0, 0);
    m_tag = 0; m_valid = 0; m_ill = 0; m_unit = 0; m_instr = '0; m_rtag = 0;

    // Reset state
    do_reset();
    check_eq("rst_iq_ready", 32'(iq_ready), 32'd1);
    check_eq("rst_count",    32'(iq_count), 32'd0);

    // Single add: push in cycle 0, dispatch visible in cycle 2 with tag 0
    set_ready(1, 1, 1);
    fe_valid = 1'b1; fe_instr = 32'h0000_0001;
    cycle();
    fe_valid = 1'b0;
    check_eq("lat_c1_valid", 32'(ds_valid), 32'd0);
    cycle();
    check_eq("lat_c2_valid", 32'(ds_valid),   32'd1);
    check_eq("lat_c2_unit",  32'(ds_unit),    32'd0);
    check_eq("lat_c2_tag",   32'(ds_rob_tag), 32'd0);
    cycle();

    // Fill with all stations blocked: fifth push refused
    set_ready(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      fe_valid = 1'b1; fe_instr = 32'h0000_0100 + 32'(i);
      cycle();
    end
    fe_valid = 1'b0;
    check_eq("full_count", 32'(iq_count), 32'd4);
    check_eq("full_ready", 32'(iq_ready), 32'd0);
    set_ready(1, 1, 1);
    for (int i = 0; i < 6; i++) cycle();

    // Stalled mul head blocks a younger add
    set_ready(0, 0, 0);
    fe_valid = 1'b1; fe_instr = 32'h4000_0000; cycle();
    fe_instr = 32'h0000_0002; cycle();
    fe_valid = 1'b0;
    set_ready(1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_no_ds", 32'(ds_valid), 32'd0);
    end
    rs_mul_ready = 1'b1;
    cycle();
    check_eq("order_mul_valid", 32'(ds_valid), 32'd1);
    check_eq("order_mul_unit",  32'(ds_unit),  32'd1);
    cycle();
    check_eq("order_add_unit",  32'(ds_unit),  32'd0);
    check_eq("order_add_instr", ds_instr,      32'h0000_0002);
    cycle();

    // Illegal word consumes no tag
    do_reset();
    set_ready(1, 1, 1);
    fe_valid = 1'b1; fe_instr = 32'hF000_0000; cycle();
    fe_instr = 32'h6000_0000; cycle();
    fe_valid = 1'b0;
    check_eq("ill_pulse", 32'(illegal),  32'd1);
    check_eq("ill_no_ds", 32'(ds_valid), 32'd0);
    cycle();
    check_eq("mem_valid", 32'(ds_valid),   32'd1);
    check_eq("mem_unit",  32'(ds_unit),    32'd2);
    check_eq("mem_tag",   32'(ds_rob_tag), 32'd0);
    check_eq("ill_gone",  32'(illegal),    32'd0);
    cycle();

    // 33 dispatches: tags 0..31 then 0
    do_reset();
    set_ready(1, 1, 1);
    seen = 0;
    for (int i = 0; i < 36; i++) begin
      fe_valid = (i < 33); fe_instr = 32'(i);
      cycle();
      if (ds_valid) begin
        check_eq("wrap_tag", 32'(ds_rob_tag), 32'(seen % ROB_DEPTH));
        seen++;
      end
    end
    check_eq("wrap_total", 32'(seen), 32'd33);
    // rob_full stalls with tag held
    fe_valid = 1'b1; fe_instr = 32'h0000_0077; rob_full = 1'b1;
    cycle();
    fe_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("robfull_stall", 32'(ds_valid),   32'd0);
      check_eq("robfull_tag",   32'(ds_rob_tag), 32'd0);
    end
    rob_full = 1'b0;
    cycle();
    check_eq("robfull_release_tag", 32'(ds_rob_tag), 32'd1);

    // Flush with three entries queued and fetch still active
    set_ready(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      fe_valid = 1'b1; fe_instr = 32'h1000_0000 + 32'(i); cycle();
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0; fe_valid = 1'b0;
    check_eq("flush_count", 32'(iq_count), 32'd0);
    check_eq("flush_no_ds", 32'(ds_valid), 32'd0);
    cycle();

    // Reset mid-stream
    set_ready(1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      fe_valid = 1'b1; fe_instr = 32'h5000_0000 + 32'(i); cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0; fe_valid = 1'b0;
    check_eq("midrst_valid", 32'(ds_valid),   32'd0);
    check_eq("midrst_instr", ds_instr,        32'd0);
    check_eq("midrst_tag",   32'(ds_rob_tag), 32'd0);
    check_eq("midrst_ready", 32'(iq_ready),   32'd1);
    cycle();

    // Random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      fe_valid     = ($urandom_range(0, 99) < 60);
      fe_instr     = {4'($urandom_range(0, 9) < 8 ? $urandom_range(0, 7) : $urandom_range(8, 15)),
                      28'($urandom)};
      rs_add_ready = ($urandom_range(0, 99) < 70);
      rs_mul_ready = ($urandom_range(0, 99) < 50);
      rs_mem_ready = ($urandom_range(0, 99) < 60);
      rob_full     = ($urandom_range(0, 99) < 10);
      flush        = ($urandom_range(0, 99) < 3);
      rst          = ($urandom_range(0, 999) < 5);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iq_dispatch.md
IQ_DISPATCH -- requirements
Module: iq_dispatch

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, meaning the number of instruction-queue entries (a power of two).
REQ-002 SHALL have parameter ROB_DEPTH, default 32, meaning the reorder-buffer size; the tag width is log2(ROB_DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port fe_valid, input, 1, fetch presents an instruction this cycle.
REQ-006 SHALL have port fe_instr, input, 32, the fetched instruction word.
REQ-007 SHALL have port iq_ready, output, 1, queue not full; a push occurs only when fe_valid and iq_ready are both high.
REQ-008 SHALL have port flush, input, 1, discard all queued instructions.
REQ-009 SHALL have ports rs_add_ready, rs_mul_ready and rs_mem_ready, input, 1 each, meaning the target reservation station can take one instruction next cycle.
REQ-010 SHALL have port rob_full, input, 1, no free ROB entry.
REQ-011 SHALL have port ds_valid, output, 1, a registered one-cycle dispatch pulse.
REQ-012 SHALL have port ds_unit, output, 2, target unit: 0 add, 1 mul, 2 mem.
REQ-013 SHALL have port ds_instr, output, 32, the dispatched instruction.
REQ-014 SHALL have port ds_rob_tag, output, 5, the allocated ROB tag.
REQ-015 SHALL have port illegal, output, 1, a registered one-cycle pulse when an undecodable head instruction is dropped.
REQ-016 SHALL have port iq_count, output, 3, the current queue occupancy (0..IQ_DEPTH).

Function
REQ-017 SHALL decode unit from fe_instr[31:28] as follows: 0000-0011 add; 0100-0101 mul; 0110-0111 mem; 1000-1111 illegal.
REQ-018 SHALL store each pushed word at the tail; the word becomes the head no earlier than the cycle after the push (no bypass from push to dispatch).
REQ-019 SHALL pop a legal head when all of the following hold at the edge: queue non-empty, the target unit's ready is high, rob_full is low, flush is low.
REQ-020 On a legal pop, SHALL drive ds_valid=1 for the next cycle only, with ds_instr, ds_unit and ds_rob_tag loaded from the head, then increment the tag counter modulo ROB_DEPTH (31 wraps to 0).
REQ-021 SHALL pop an illegal head regardless of ready/rob_full, pulse illegal for one cycle, hold ds_valid low, and leave the tag counter unchanged.
REQ-022 SHALL dispatch strictly in order: a stalled head blocks all younger entries; at most one pop per cycle.
REQ-023 SHALL derive iq_ready solely from the registered count (iq_ready = count < IQ_DEPTH); when full, a push is refused even if a pop occurs in the same cycle.
REQ-024 On a simultaneous push and pop, SHALL leave count unchanged and advance both pointers.
REQ-025 SHALL wrap head and tail pointers modulo IQ_DEPTH.
REQ-026 flush SHALL have priority over push and pop: in the next cycle count, head and tail are 0, ds_valid and illegal are 0, fe input is ignored, and the tag counter is unchanged.
REQ-027 SHALL hold ds_instr, ds_unit and ds_rob_tag stable while ds_valid is low.

Reset
REQ-028 On rst high at an edge, SHALL set count, head, tail and the tag counter to 0, ds_valid to 0, illegal to 0, ds_instr to 0, ds_unit to 0, and ds_rob_tag to 0; iq_ready is then 1.
REQ-029 rst SHALL override flush, push and pop; an instruction mid-dispatch is discarded and no pulse is emitted in the cycle after reset.

Structure
REQ-030 SHALL take IQ_DEPTH/ROB_DEPTH defaults, the unit codes, and the opcode range constants from shared package tomasulo_pkg.
REQ-031 SHALL implement queue storage, pointers and count in sub-module iq_fifo; decode, the dispatch decision and tag allocation live in iq_dispatch.

Verification
REQ-032 Push 0x0000_0001 in cycle 0 with all readys high -> ds_valid in cycle 2, ds_unit=0, ds_rob_tag=0.
REQ-033 Push 5 words back-to-back with all readys low -> iq_ready falls after the 4th push, the 5th is refused, iq_count=4.
REQ-034 Head is mul (0x4...) with rs_mul_ready=0 and the next entry is add -> no dispatch until rs_mul_ready=1, then mul dispatches followed by add, preserving order.
REQ-035 Push 0xF000_0000 then 0x6000_0000 -> illegal pulse, then mem dispatch with tag 0 (no tag consumed by the illegal word).
REQ-036 Dispatch 33 legal instructions -> tags run 0..31 then 0; rob_full=1 stalls with tag held.
REQ-037 flush with 3 entries queued and fe_valid=1 -> next cycle iq_count=0 and no ds_valid; rst mid-stream -> all outputs return to their reset values.
